// File: rtl/sidi_audio_pkg.sv
// Shared definitions for the sigma-delta audio output stage.
//   DefaultDw         default PCM sample width
//   MaxDw             widest sample the helper function handles (DW must stay below this)
//   MidScale          offset-binary midscale for the default width
//   sample_t / step_t signed sample and signed DW+1 ramp step at the default width
//   to_offset_binary  flips the sign bit of a w-bit two's complement sample
package sidi_audio_pkg;

   localparam int unsigned DefaultDw = 16;
   localparam int unsigned MaxDw     = 32;

   localparam logic [DefaultDw-1:0] MidScale = DefaultDw'(1) << (DefaultDw - 1);

   typedef logic signed [DefaultDw-1:0] sample_t;
   typedef logic signed [DefaultDw:0]   step_t;

   // Two's complement to offset-binary: 0x8000 -> 0, 0x0000 -> 0x8000, 0x7FFF -> 0xFFFF.
   // Bits above w-1 are left as they came in; callers keep only the low w bits.
   function automatic logic [MaxDw-1:0] to_offset_binary(input logic [MaxDw-1:0] s,
                                                          input int unsigned     w);
      return s ^ (MaxDw'(1) << (w - 1));
   endfunction

endpackage

// File: rtl/sidi_sdm_chan.sv
// One audio channel: sample capture, linear ramp toward the captured target,
// offset-binary conversion and a first-order sigma-delta modulator.
//   clk, reset_n  clock and asynchronous active-low reset
//   tick          modulator/interpolator enable
//   pcm           signed sample, captured when pcm_valid is high
//   pcm_valid     one-clock capture strobe
//   mute          level; forces the target to 0, edges re-trigger a ramp
//   audio         registered 1-bit sigma-delta output
//   ramp_active   ramp counter is nonzero
module sidi_sdm_chan
   import sidi_audio_pkg::*;
#(
   parameter int unsigned DW         = DefaultDw,
   parameter int unsigned RAMP_SHIFT = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick,
   input  logic signed [DW-1:0] pcm,
   input  logic                 pcm_valid,
   input  logic                 mute,
   output logic                 audio,
   output logic                 ramp_active
);

   localparam int unsigned     CntW    = RAMP_SHIFT + 1;
   localparam logic [CntW-1:0] RampLen = CntW'(1) << RAMP_SHIFT;

   logic signed [DW-1:0] target_q, target_d;
   logic signed [DW-1:0] cur_q, cur_d;
   logic signed [DW-1:0] held_q, held_d;
   logic signed [DW:0]   step_q, step_d;
   logic [CntW-1:0]      ramp_cnt_q, ramp_cnt_d;
   logic [DW-1:0]        acc_q, acc_d;
   logic                 audio_q, audio_d;
   logic                 mute_q;

   logic                 capture;
   logic signed [DW-1:0] new_target;
   logic signed [DW:0]   diff;
   logic [DW:0]          ramp_sum;
   logic [MaxDw-1:0]     u_wide;
   logic [DW-1:0]        u;
   logic [DW:0]          sum;
   logic                 unused_bits;

   always_comb begin
      // A mute edge re-captures the last sample so the output ramps instead of clicking.
      capture    = pcm_valid | (mute ^ mute_q);
      held_d     = pcm_valid ? pcm : held_q;
      new_target = mute ? '0 : held_d;
      diff       = {new_target[DW-1], new_target} - {cur_q[DW-1], cur_q};
      ramp_sum   = {cur_q[DW-1], cur_q} + step_q;

      target_d   = target_q;
      step_d     = step_q;
      ramp_cnt_d = ramp_cnt_q;
      cur_d      = cur_q;

      if (capture) begin
         target_d   = new_target;
         step_d     = diff >>> RAMP_SHIFT;
         ramp_cnt_d = RampLen;
      end else if (tick) begin
         if (ramp_cnt_q > CntW'(1)) begin
            cur_d      = ramp_sum[DW-1:0];
            ramp_cnt_d = ramp_cnt_q - CntW'(1);
         end else if (ramp_cnt_q == CntW'(1)) begin
            // Final step snaps to the target, absorbing the step truncation error.
            cur_d      = target_q;
            ramp_cnt_d = '0;
         end
      end

      u_wide  = to_offset_binary(MaxDw'(cur_q), DW);
      u       = u_wide[DW-1:0];
      sum     = {1'b0, acc_q} + {1'b0, u};
      acc_d   = tick ? sum[DW-1:0] : acc_q;
      audio_d = tick ? sum[DW] : audio_q;
   end

   assign unused_bits = ^{u_wide[MaxDw-1:DW], ramp_sum[DW]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         target_q   <= '0;
         cur_q      <= '0;
         held_q     <= '0;
         step_q     <= '0;
         ramp_cnt_q <= '0;
         acc_q      <= '0;
         audio_q    <= 1'b0;
         mute_q     <= 1'b0;
      end else begin
         target_q   <= target_d;
         cur_q      <= cur_d;
         held_q     <= held_d;
         step_q     <= step_d;
         ramp_cnt_q <= ramp_cnt_d;
         acc_q      <= acc_d;
         audio_q    <= audio_d;
         mute_q     <= mute;
      end
   end

   assign audio       = audio_q;
   assign ramp_active = |ramp_cnt_q;

endmodule

// File: rtl/sidi_audio_sdm.sv
// Stereo audio output stage: tick divider plus two sigma-delta channels.
//   clk, reset_n      clock and asynchronous active-low reset
//   pcm_l, pcm_r      signed stereo samples, captured on pcm_valid
//   pcm_valid         one-clock capture strobe
//   mute              level; ramps both channels to midscale while high
//   audio_l, audio_r  1-bit sigma-delta pin outputs
//   busy              either channel is still ramping
module sidi_audio_sdm
   import sidi_audio_pkg::*;
#(
   parameter int unsigned DW         = DefaultDw,
   parameter int unsigned CE_DIV     = 1,
   parameter int unsigned RAMP_SHIFT = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic signed [DW-1:0] pcm_l,
   input  logic signed [DW-1:0] pcm_r,
   input  logic                 pcm_valid,
   input  logic                 mute,
   output logic                 audio_l,
   output logic                 audio_r,
   output logic                 busy
);

   localparam int unsigned DivW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic            tick;
   logic            ramp_l, ramp_r;

   // With CE_DIV == 1 the counter sits at 0 and tick is permanently high.
   always_comb begin
      tick      = (div_cnt_q == DivW'(CE_DIV - 1));
      div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   sidi_sdm_chan #(
      .DW         (DW),
      .RAMP_SHIFT (RAMP_SHIFT)
   ) u_chan_l (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick),
      .pcm         (pcm_l),
      .pcm_valid   (pcm_valid),
      .mute        (mute),
      .audio       (audio_l),
      .ramp_active (ramp_l)
   );

   sidi_sdm_chan #(
      .DW         (DW),
      .RAMP_SHIFT (RAMP_SHIFT)
   ) u_chan_r (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick),
      .pcm         (pcm_r),
      .pcm_valid   (pcm_valid),
      .mute        (mute),
      .audio       (audio_r),
      .ramp_active (ramp_r)
   );

   assign busy = ramp_l | ramp_r;

endmodule

// File: tb/tb_sidi_audio_sdm.sv
// Bench for sidi_audio_sdm: three configurations share one stimulus stream; a
// behavioural model predicts each clock's outputs, which go through a queue.
module tb_sidi_audio_sdm;
   import sidi_audio_pkg::*;

   localparam int NInst = 3;
   localparam int CeDiv [NInst] = '{1, 1, 4};
   localparam int Rs    [NInst] = '{4, 0, 4};

   logic               clk;
   logic               reset_n;
   logic signed [15:0] pcm_l, pcm_r;
   logic               pcm_valid, mute;
   logic [NInst-1:0]   a_l, a_r, bsy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sidi_audio_sdm #(.DW(16), .CE_DIV(1), .RAMP_SHIFT(4)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_valid(pcm_valid),
      .mute(mute), .audio_l(a_l[0]), .audio_r(a_r[0]), .busy(bsy[0]));
   sidi_audio_sdm #(.DW(16), .CE_DIV(1), .RAMP_SHIFT(0)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_valid(pcm_valid),
      .mute(mute), .audio_l(a_l[1]), .audio_r(a_r[1]), .busy(bsy[1]));
   sidi_audio_sdm #(.DW(16), .CE_DIV(4), .RAMP_SHIFT(4)) u_dut_c (
      .clk(clk), .reset_n(reset_n), .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_valid(pcm_valid),
      .mute(mute), .audio_l(a_l[2]), .audio_r(a_r[2]), .busy(bsy[2]));

   // Model state, plain integers
   int m_div  [NInst];
   int m_tgt  [NInst][2];
   int m_cur  [NInst][2];
   int m_step [NInst][2];
   int m_cnt  [NInst][2];
   int m_acc  [NInst][2];
   int m_held [NInst][2];
   bit m_out  [NInst][2];
   bit m_mprev;

   int         total, bad;
   logic [8:0] exp_q[$];
   bit         checking, busy_win, ones_win;
   int         busy_cnt, ones_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   task automatic model_clear();
      m_mprev = 1'b0;
      for (int k = 0; k < NInst; k++) begin
         m_div[k] = 0;
         for (int c = 0; c < 2; c++) begin
            m_tgt[k][c] = 0; m_cur[k][c] = 0; m_step[k][c] = 0; m_cnt[k][c] = 0;
            m_acc[k][c] = 0; m_held[k][c] = 0; m_out[k][c] = 1'b0;
         end
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      bit tick, cap;
      int p, u;
      if (!reset_n) begin
         model_clear();
         return;
      end
      for (int k = 0; k < NInst; k++) begin
         tick = (m_div[k] == CeDiv[k] - 1);
         m_div[k] = tick ? 0 : m_div[k] + 1;
         for (int c = 0; c < 2; c++) begin
            p = (c == 0) ? int'(pcm_l) : int'(pcm_r);
            cap = 1'b0;
            if (pcm_valid) begin
               m_held[k][c] = p;
               m_tgt[k][c]  = mute ? 0 : p;
               cap = 1'b1;
            end else if (mute != m_mprev) begin
               m_tgt[k][c] = mute ? 0 : m_held[k][c];
               cap = 1'b1;
            end
            if (tick) begin
               u = m_cur[k][c] + int'(MidScale);
               m_acc[k][c] += u;
               m_out[k][c] = (m_acc[k][c] >= 65536);
               if (m_out[k][c]) m_acc[k][c] -= 65536;
            end
            if (cap) begin
               m_step[k][c] = (m_tgt[k][c] - m_cur[k][c]) >>> Rs[k];
               m_cnt[k][c]  = 1 << Rs[k];
            end else if (tick && m_cnt[k][c] > 1) begin
               m_cur[k][c] += m_step[k][c];
               m_cnt[k][c]--;
            end else if (tick && m_cnt[k][c] == 1) begin
               m_cur[k][c] = m_tgt[k][c];
               m_cnt[k][c] = 0;
            end
         end
      end
      m_mprev = mute;
   endtask

   task automatic cycle();
      logic [8:0] e;
      model_step();
      for (int k = 0; k < NInst; k++)
         e[3*k +: 3] = {(m_cnt[k][0] != 0 || m_cnt[k][1] != 0), m_out[k][1], m_out[k][0]};
      if (checking) exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (checking) begin
         e = exp_q.pop_front();
         for (int k = 0; k < NInst; k++)
            check($sformatf("out%0d", k), 32'({bsy[k], a_r[k], a_l[k]}), 32'(e[3*k +: 3]));
      end
      if (busy_win) busy_cnt += int'(bsy[0]);
      if (ones_win) ones_cnt += int'(a_l[1]);
   endtask

   task automatic strobe(input logic signed [15:0] l, input logic signed [15:0] r);
      pcm_l = l;
      pcm_r = r;
      pcm_valid = 1'b1;
      cycle();
      pcm_valid = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0;
      reset_n = 1'b0; pcm_l = '0; pcm_r = '0; pcm_valid = 1'b0; mute = 1'b0;
      checking = 1'b1; busy_win = 1'b0; ones_win = 1'b0;
      busy_cnt = 0; ones_cnt = 0;
      model_clear();
      #1;
      for (int k = 0; k < NInst; k++)
         check($sformatf("reset%0d", k), 32'({bsy[k], a_r[k], a_l[k]}), 32'd0);
      repeat (3) cycle();
      reset_n = 1'b1;
      repeat (8) cycle();                       // midscale idle: alternating bits

      busy_win = 1'b1;                          // plain ramp 0 -> 0x1000
      strobe(16'sh1000, -16'sh2000);
      repeat (70) cycle();
      busy_win = 1'b0;
      check("busy_len", 32'(busy_cnt), 32'd16);

      strobe(16'sh0000, 16'sh3000);             // back to 0, then restart mid-ramp
      repeat (70) cycle();
      strobe(16'sh1000, 16'sh0100);
      repeat (8) cycle();
      strobe(-16'sd4096, 16'sh7FFF);
      repeat (70) cycle();

      strobe(16'sh4000, -16'sh4000);            // mute ramp down and back up
      repeat (70) cycle();
      mute = 1'b1;
      repeat (70) cycle();
      mute = 1'b0;
      repeat (8) cycle();

      #2;                                       // asynchronous reset mid-ramp
      reset_n = 1'b0;
      model_clear();
      #1;
      for (int k = 0; k < NInst; k++)
         check($sformatf("async_rst%0d", k), 32'({bsy[k], a_r[k], a_l[k]}), 32'd0);
      repeat (2) cycle();
      reset_n = 1'b1;

      strobe(16'sh7FFF, 16'sh0000);             // full-scale density, RAMP_SHIFT=0 instance
      cycle();
      checking = 1'b0;
      ones_win = 1'b1;
      repeat (65536) cycle();
      ones_win = 1'b0;
      checking = 1'b1;
      check("ones_65536", 32'(ones_cnt), 32'd65535);
      repeat (4) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
